// File: rtl/ssd_pkg.sv
// Shared types for the seven-segment display arbiter: character codes and arbiter state.
package ssd_pkg;

    typedef logic [4:0] char_code_t;

    localparam char_code_t BLANK_CODE = 5'b11111;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_HOLD = 1'b1
    } arb_state_t;

endpackage

// File: rtl/ssd_display_arbiter_rr_picker.sv
// Combinational selector: first set request bit at or after start, wrapping around,
// so the requester just below start is searched last.
module rr_picker
    import ssd_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   start,
    output logic [NUM_REQ-1:0] winner,
    output logic               valid
);

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        // Upper segment [start, NUM_REQ) first, then the wrapped segment [0, start).
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!valid && req[i] && (i >= 32'(start))) begin
                winner[i] = 1'b1;
                valid     = 1'b1;
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!valid && req[i] && (i < 32'(start))) begin
                winner[i] = 1'b1;
                valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ssd_display_arbiter.sv
// Shares a two-digit display among NUM_REQ requesters, each grant owning it for up to
// HOLD_CYCLES clocks. Define SSD_ARB_FIXED_PRI_EN for fixed priority instead of round-robin.
module ssd_display_arbiter
    import ssd_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned HOLD_CYCLES = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ*5-1:0] req_digit1,
    input  logic [NUM_REQ*5-1:0] req_digit0,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [4:0]           digit1,
    output logic [4:0]           digit0,
    output logic                 busy
);

    localparam int unsigned      IDX_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [15:0]      HOLD_RELOAD = 16'(HOLD_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_REQ - 1);

    arb_state_t         state_q, state_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    char_code_t         digit1_q, digit1_d;
    char_code_t         digit0_q, digit0_d;
    logic               busy_q, busy_d;

    logic [IDX_W-1:0]   pick_start;
    logic [NUM_REQ-1:0] pick_onehot;
    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;
    logic               owner_req;
    logic               release_hold;
    logic               grant_now;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req    (req),
        .start  (pick_start),
        .winner (pick_onehot),
        .valid  (pick_valid)
    );

    // owner_q doubles as last_owner: it keeps the most recent winner after release.
    always_comb begin
`ifdef SSD_ARB_FIXED_PRI_EN
        pick_start = '0;
`else
        pick_start = (owner_q == LAST_IDX) ? '0 : owner_q + IDX_W'(1);
`endif
        pick_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_onehot[i]) begin
                pick_idx = IDX_W'(i);
            end
        end
        owner_req = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (owner_q == IDX_W'(i)) begin
                owner_req = req[i];
            end
        end
        release_hold = (state_q == ARB_HOLD) && ((cnt_q == '0) || !owner_req);
        grant_now    = pick_valid && ((state_q == ARB_IDLE) || release_hold);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ARB_IDLE;
            cnt_q    <= '0;
            owner_q  <= LAST_IDX;
            gnt_q    <= '0;
            busy_q   <= 1'b0;
            digit1_q <= BLANK_CODE;
            digit0_q <= BLANK_CODE;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            owner_q  <= owner_d;
            gnt_q    <= gnt_d;
            busy_q   <= busy_d;
            digit1_q <= digit1_d;
            digit0_q <= digit0_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (grant_now) begin
                    state_d = ARB_HOLD;
                    cnt_d   = HOLD_RELOAD;
                    owner_d = pick_idx;
                end
            end
            ARB_HOLD: begin
                if (grant_now) begin
                    cnt_d   = HOLD_RELOAD;
                    owner_d = pick_idx;
                end else if (release_hold) begin
                    state_d = ARB_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // On a handoff the outgoing owner's codes are still shown for one cycle, so there is no blank gap.
    always_comb begin
        gnt_d    = '0;
        busy_d   = (state_d == ARB_HOLD);
        digit1_d = BLANK_CODE;
        digit0_d = BLANK_CODE;
        if (state_d == ARB_HOLD) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                gnt_d[i] = (owner_d == IDX_W'(i));
            end
        end
        if ((state_q == ARB_HOLD) && (state_d == ARB_HOLD)) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (owner_q == IDX_W'(i)) begin
                    digit1_d = req_digit1[i*5 +: 5];
                    digit0_d = req_digit0[i*5 +: 5];
                end
            end
        end
    end

    assign gnt    = gnt_q;
    assign busy   = busy_q;
    assign digit1 = digit1_q;
    assign digit0 = digit0_q;

endmodule

// File: tb/tb_ssd_display_arbiter.sv
// Scoreboard bench: two arbiters (HOLD_CYCLES 8 and 4) share stimulus; the driver queues
// hand-derived expected outputs per DUT and a monitor pops and compares after each edge.
module tb_ssd_display_arbiter;

    localparam logic [4:0] B = 5'h1F;

    typedef struct {
        string      nm;
        logic [3:0] g;
        logic       b;
        logic [4:0] d1;
        logic [4:0] d0;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [19:0] rd1, rd0;
    logic [3:0]  gnt8, gnt4;
    logic [4:0]  d1_8, d0_8, d1_4, d0_4;
    logic        busy8, busy4;

    exp_t        q8[$];
    exp_t        q4[$];
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    event        sample_ev;

    logic [3:0]  seq_g [4];
    logic [4:0]  seq_c1[4];
    logic [4:0]  seq_c0[4];

    ssd_display_arbiter #(.NUM_REQ(4), .HOLD_CYCLES(8)) dut8 (
        .clk(clk), .reset(reset), .req(req), .req_digit1(rd1), .req_digit0(rd0),
        .gnt(gnt8), .digit1(d1_8), .digit0(d0_8), .busy(busy8)
    );

    ssd_display_arbiter #(.NUM_REQ(4), .HOLD_CYCLES(4)) dut4 (
        .clk(clk), .reset(reset), .req(req), .req_digit1(rd1), .req_digit0(rd0),
        .gnt(gnt4), .digit1(d1_4), .digit0(d0_4), .busy(busy4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        ->sample_ev;
    end

    task automatic check(input string tag, input exp_t e, input logic [3:0] g, input logic b,
                         input logic [4:0] d1, input logic [4:0] d0);
        n_cmp++;
        if (g !== e.g || b !== e.b || d1 !== e.d1 || d0 !== e.d0) begin
            n_bad++;
            $display("FAIL %s:%s got gnt=%b busy=%b d1=%h d0=%h, expected gnt=%b busy=%b d1=%h d0=%h",
                     tag, e.nm, g, b, d1, d0, e.g, e.b, e.d1, e.d0);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(sample_ev);
            if (q8.size() > 0) begin
                e = q8.pop_front();
                check("h8", e, gnt8, busy8, d1_8, d0_8);
            end
            if (q4.size() > 0) begin
                e = q4.pop_front();
                check("h4", e, gnt4, busy4, d1_4, d0_4);
            end
        end
    end

    task automatic e8(input string nm, input logic [3:0] g, input logic b,
                      input logic [4:0] d1, input logic [4:0] d0);
        exp_t e;
        e.nm = nm; e.g = g; e.b = b; e.d1 = d1; e.d0 = d0;
        q8.push_back(e);
    endtask

    task automatic e4(input string nm, input logic [3:0] g, input logic b,
                      input logic [4:0] d1, input logic [4:0] d0);
        exp_t e;
        e.nm = nm; e.g = g; e.b = b; e.d1 = d1; e.d0 = d0;
        q4.push_back(e);
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    initial begin
        seq_g  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        seq_c1 = '{5'h10, 5'h03, 5'h12, 5'h14};
        seq_c0 = '{5'h11, 5'h07, 5'h13, 5'h15};
        reset = 1'b1;
        req   = 4'b0000;
        rd1   = {5'h14, 5'h12, 5'h03, 5'h10};
        rd0   = {5'h15, 5'h13, 5'h07, 5'h11};

        // Reset state, then ten idle cycles
        nxt();
        e8("rst", 4'b0000, 1'b0, B, B);
        e4("rst", 4'b0000, 1'b0, B, B);
        nxt();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            e8("idle", 4'b0000, 1'b0, B, B);
            e4("idle", 4'b0000, 1'b0, B, B);
            nxt();
        end

        // Single requester 1, HOLD 8: grant, digits a cycle later, seamless re-grant, live code update
        req = 4'b0010;
        e8("a_gnt", 4'b0010, 1'b1, B, B);
        nxt();
        for (int i = 0; i < 8; i++) begin
            e8("a_hold", 4'b0010, 1'b1, 5'h03, 5'h07);
            nxt();
        end
        rd1[9:5] = 5'h05;
        rd0[9:5] = 5'h06;
        for (int i = 0; i < 3; i++) begin
            e8("a_upd", 4'b0010, 1'b1, 5'h05, 5'h06);
            nxt();
        end
        req = 4'b0000;
        e8("a_rel_idle", 4'b0000, 1'b0, B, B);
        nxt();
        e8("a_idle", 4'b0000, 1'b0, B, B);
        nxt();

        // Owner 2 drops at its third cycle with req[0] pending; reload seen via later handoff to 3
        req = 4'b0100;
        e8("a2_gnt", 4'b0100, 1'b1, B, B);
        nxt();
        req = 4'b0101;
        e8("a2_hold", 4'b0100, 1'b1, 5'h12, 5'h13);
        nxt();
        e8("a2_hold", 4'b0100, 1'b1, 5'h12, 5'h13);
        nxt();
        req = 4'b0001;
        e8("a2_drop", 4'b0001, 1'b1, 5'h12, 5'h13);
        nxt();
        req = 4'b1001;
        for (int i = 0; i < 7; i++) begin
            e8("a2_reload", 4'b0001, 1'b1, 5'h10, 5'h11);
            nxt();
        end
        e8("a2_expire", 4'b1000, 1'b1, 5'h10, 5'h11);
        nxt();
        e8("a2_own3", 4'b1000, 1'b1, 5'h14, 5'h15);
        nxt();

        // All four requesting, HOLD 4: rotation 0,1,2,3,0 with no gap
        rd1[9:5] = 5'h03;
        rd0[9:5] = 5'h07;
        reset = 1'b1;
        req   = 4'b0000;
        e4("b_rst", 4'b0000, 1'b0, B, B);
        nxt();
        reset = 1'b0;
        req   = 4'b1111;
        e4("b_gnt", 4'b0001, 1'b1, B, B);
        nxt();
        for (int gi = 0; gi < 4; gi++) begin
            for (int c = 0; c < 3; c++) begin
                e4("b_hold", seq_g[gi], 1'b1, seq_c1[gi], seq_c0[gi]);
                nxt();
            end
            e4("b_handoff", seq_g[(gi + 1) % 4], 1'b1, seq_c1[gi], seq_c0[gi]);
            nxt();
        end
        e4("b_wrap", 4'b0001, 1'b1, 5'h10, 5'h11);
        nxt();

        // Asynchronous reset in the middle of a grant, then resume with requester 2
        #1 reset = 1'b1;
        #1;
        e4("c_async", 4'b0000, 1'b0, B, B);
        ->sample_ev;
        e4("c_rst_hold", 4'b0000, 1'b0, B, B);
        req = 4'b0100;
        nxt();
        reset = 1'b0;
        e4("c_resume", 4'b0100, 1'b1, B, B);
        nxt();
        e4("c_digits", 4'b0100, 1'b1, 5'h12, 5'h13);
        nxt();

        // Requesters 1 and 3
        reset = 1'b1;
        req   = 4'b0000;
        e4("d_rst", 4'b0000, 1'b0, B, B);
        nxt();
        reset = 1'b0;
        req   = 4'b1010;
        e4("d_gnt", 4'b0010, 1'b1, B, B);
        nxt();
        for (int i = 0; i < 3; i++) begin
            e4("d_hold", 4'b0010, 1'b1, 5'h03, 5'h07);
            nxt();
        end
`ifdef SSD_ARB_FIXED_PRI_EN
        for (int i = 0; i < 6; i++) begin
            e4("d_fixed", 4'b0010, 1'b1, 5'h03, 5'h07);
            nxt();
        end
`else
        e4("d_rr3", 4'b1000, 1'b1, 5'h03, 5'h07);
        nxt();
        for (int i = 0; i < 3; i++) begin
            e4("d_hold3", 4'b1000, 1'b1, 5'h14, 5'h15);
            nxt();
        end
        e4("d_rr1", 4'b0010, 1'b1, 5'h14, 5'h15);
        nxt();
        e4("d_hold1", 4'b0010, 1'b1, 5'h03, 5'h07);
        nxt();
`endif

        req = 4'b0000;
        nxt();
        nxt();
        if (q8.size() + q4.size() != 0) begin
            $display("FAIL drain: %0d expectations never compared, expected 0", q8.size() + q4.size());
            n_bad = n_bad + q8.size() + q4.size();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
